// File: rtl/hazard_pkg.sv
// Shared types for the hazard controller: scoreboard entry layout and depth.
package hazard_pkg;

    localparam int RAW_W    = 5;
    localparam int SB_DEPTH = 3;

    typedef struct packed {
        logic             valid;
        logic [RAW_W-1:0] rd;
        logic             is_load;
    } sb_entry_t;

    function automatic sb_entry_t sb_empty();
        sb_entry_t e;
        e = '0;
        return e;
    endfunction

endpackage

// File: rtl/hazard_sb.sv
// Destination-register scoreboard shifting EX -> MEM -> WB; entry 0 is EX.
module hazard_sb
    import hazard_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      hold,
    input  logic      drop,
    input  sb_entry_t ins,
    output sb_entry_t ex,
    output sb_entry_t mem,
    output sb_entry_t wb
);

    sb_entry_t sb [SB_DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SB_DEPTH; i++) sb[i] <= sb_empty();
        end else if (!hold) begin
            for (int i = SB_DEPTH-1; i > 0; i--) sb[i] <= sb[i-1];
            sb[0] <= drop ? sb_empty() : ins;
        end
    end

    assign ex  = sb[0];
    assign mem = sb[1];
    assign wb  = sb[2];

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: hold/bubble/flush generation plus stall counter.
// Define CFG_FWD_EN when the datapath has full EX/MEM/WB forwarding.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int RAW  = RAW_W,
    parameter int CNTW = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_id_valid,
    input  logic            i_id_rs_1_en,
    input  logic            i_id_rs_2_en,
    input  logic [RAW-1:0]  i_id_rs_1,
    input  logic [RAW-1:0]  i_id_rs_2,
    input  logic            i_id_rd_en,
    input  logic [RAW-1:0]  i_id_rd,
    input  logic            i_id_is_load,
    input  logic            i_ex_jump,
    input  logic            i_mem_busy,
    output logic            o_hold_if,
    output logic            o_hold_id,
    output logic            o_hold_back,
    output logic            o_bubble_ex,
    output logic            o_flush,
    output logic [CNTW-1:0] o_stall_cnt
);

    sb_entry_t sb_ex, sb_mem, sb_wb, sb_ins;
    logic      sb_hold, sb_drop;
    logic      hazard;
    logic [CNTW-1:0] cnt;

    // x0 is never a real producer, so an rd of zero can never match.
    function automatic logic src_match(sb_entry_t e, logic v, logic en_1, logic [RAW-1:0] rs_1,
                                       logic en_2, logic [RAW-1:0] rs_2);
        logic live;
        live = e.valid && (e.rd != '0);
        return v && live && ((en_1 && rs_1 == e.rd) || (en_2 && rs_2 == e.rd));
    endfunction

    logic m_ex, m_mem, m_wb;
    assign m_ex  = src_match(sb_ex,  i_id_valid, i_id_rs_1_en, i_id_rs_1, i_id_rs_2_en, i_id_rs_2);
    assign m_mem = src_match(sb_mem, i_id_valid, i_id_rs_1_en, i_id_rs_1, i_id_rs_2_en, i_id_rs_2);
    assign m_wb  = src_match(sb_wb,  i_id_valid, i_id_rs_1_en, i_id_rs_1, i_id_rs_2_en, i_id_rs_2);

`ifdef CFG_FWD_EN
    assign hazard = m_ex && sb_ex.is_load;
`else
    // WB counts too: the regfile write port is not bypassed to reads.
    assign hazard = m_ex || m_mem || m_wb;
`endif

    always_comb begin
        o_hold_if   = 1'b0;
        o_hold_id   = 1'b0;
        o_hold_back = 1'b0;
        o_bubble_ex = 1'b0;
        o_flush     = 1'b0;
        sb_hold     = 1'b0;
        sb_drop     = 1'b0;
        if (rst) begin
            o_flush = 1'b1;
        end else if (i_mem_busy) begin
            // EX is frozen too, so a pending jump reasserts once memory frees up.
            o_hold_if   = 1'b1;
            o_hold_id   = 1'b1;
            o_hold_back = 1'b1;
            sb_hold     = 1'b1;
        end else if (i_ex_jump) begin
            o_flush     = 1'b1;
            o_bubble_ex = 1'b1;
            sb_drop     = 1'b1;
        end else if (hazard) begin
            o_hold_if   = 1'b1;
            o_hold_id   = 1'b1;
            o_bubble_ex = 1'b1;
            sb_drop     = 1'b1;
        end
    end

    always_comb begin
        sb_ins         = sb_empty();
        sb_ins.valid   = i_id_valid && i_id_rd_en;
        sb_ins.rd      = i_id_rd;
        sb_ins.is_load = i_id_is_load;
    end

    hazard_sb u_sb (
        .clk  (clk),
        .rst  (rst),
        .hold (sb_hold),
        .drop (sb_drop),
        .ins  (sb_ins),
        .ex   (sb_ex),
        .mem  (sb_mem),
        .wb   (sb_wb)
    );

    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (!i_mem_busy && !i_ex_jump && hazard && cnt != '1)
            cnt <= cnt + 1'b1;
    end

    assign o_stall_cnt = cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl; expectations follow CFG_FWD_EN when defined.
module tb_hazard_ctrl;
    import hazard_pkg::*;

    localparam int CNTW = 4;
    localparam int CMAX = 15;
`ifdef CFG_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic clk, rst;
    logic i_id_valid, i_id_rs_1_en, i_id_rs_2_en, i_id_rd_en, i_id_is_load;
    logic [4:0] i_id_rs_1, i_id_rs_2, i_id_rd;
    logic i_ex_jump, i_mem_busy;
    logic o_hold_if, o_hold_id, o_hold_back, o_bubble_ex, o_flush;
    logic [CNTW-1:0] o_stall_cnt;

    hazard_ctrl #(.RAW(5), .CNTW(CNTW)) dut (
        .clk(clk), .rst(rst),
        .i_id_valid(i_id_valid), .i_id_rs_1_en(i_id_rs_1_en), .i_id_rs_2_en(i_id_rs_2_en),
        .i_id_rs_1(i_id_rs_1), .i_id_rs_2(i_id_rs_2), .i_id_rd_en(i_id_rd_en),
        .i_id_rd(i_id_rd), .i_id_is_load(i_id_is_load), .i_ex_jump(i_ex_jump),
        .i_mem_busy(i_mem_busy), .o_hold_if(o_hold_if), .o_hold_id(o_hold_id),
        .o_hold_back(o_hold_back), .o_bubble_ex(o_bubble_ex), .o_flush(o_flush),
        .o_stall_cnt(o_stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { logic [4:0] ctl; int cnt; } exp_t;
    exp_t      exp_q[$];
    sb_entry_t m_sb [3];
    int        m_cnt;
    int        n_chk, n_pass;
    logic      held;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, want);
    endtask

    function automatic logic mt(sb_entry_t e);
        return i_id_valid && e.valid && e.rd != 5'd0 &&
               ((i_id_rs_1_en && i_id_rs_1 == e.rd) || (i_id_rs_2_en && i_id_rs_2 == e.rd));
    endfunction

    // One clock: predict controls, check them mid-cycle, then advance the model.
    task automatic tick();
        exp_t      e, o;
        logic      hz;
        sb_entry_t nxt;
        hz = FWD ? (mt(m_sb[0]) && m_sb[0].is_load) : (mt(m_sb[0]) || mt(m_sb[1]) || mt(m_sb[2]));
        if (rst)             e.ctl = 5'b00001;
        else if (i_mem_busy) e.ctl = 5'b11100;
        else if (i_ex_jump)  e.ctl = 5'b00011;
        else if (hz)         e.ctl = 5'b11010;
        else                 e.ctl = 5'b00000;
        e.cnt = m_cnt;
        exp_q.push_back(e);
        #3;
        o = exp_q.pop_front();
        chk("ctl", {27'd0, o_hold_if, o_hold_id, o_hold_back, o_bubble_ex, o_flush}, {27'd0, o.ctl});
        chk("cnt", {28'd0, o_stall_cnt}, o.cnt);
        held = o_hold_id;
        nxt.valid   = i_id_valid && i_id_rd_en;
        nxt.rd      = i_id_rd;
        nxt.is_load = i_id_is_load;
        @(posedge clk);
        #1;
        if (rst) begin
            m_sb  = '{default: '0};
            m_cnt = 0;
        end else if (!i_mem_busy) begin
            if (!i_ex_jump && hz && m_cnt < CMAX) m_cnt++;
            m_sb[2] = m_sb[1];
            m_sb[1] = m_sb[0];
            m_sb[0] = (i_ex_jump || hz) ? sb_entry_t'('0) : nxt;
        end
    endtask

    task automatic idle();
        i_id_valid = 0; i_id_rs_1_en = 0; i_id_rs_2_en = 0; i_id_rd_en = 0;
        i_id_rs_1 = 0; i_id_rs_2 = 0; i_id_rd = 0; i_id_is_load = 0;
    endtask

    task automatic issue_prod(input logic [4:0] rd, input logic ld);
        idle();
        i_id_valid = 1; i_id_rd_en = 1; i_id_rd = rd; i_id_is_load = ld;
        tick();
    endtask

    task automatic set_cons(input logic [4:0] rs1, input logic [4:0] rs2);
        idle();
        i_id_valid = 1; i_id_rs_1_en = 1; i_id_rs_1 = rs1; i_id_rs_2_en = 1; i_id_rs_2 = rs2;
    endtask

    task automatic run_until_issue(output int s);
        s = 0;
        tick();
        while (held) begin
            s++;
            if (s > 8) begin
                chk("stall_bound", s, 0);
                break;
            end
            tick();
        end
        idle();
    endtask

    task automatic do_reset();
        rst = 1; idle(); i_ex_jump = 0; i_mem_busy = 0;
        tick();
        rst = 0;
    endtask

    initial begin
        int s, total;
        m_sb = '{default: '0};
        rst = 1; idle(); i_ex_jump = 0; i_mem_busy = 0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();
        chk("rst_cnt", {28'd0, o_stall_cnt}, 0);

        // load-use
        issue_prod(5'd5, 1'b1);
        set_cons(5'd5, 5'd5);
        run_until_issue(s);
        chk("ld_use_stalls", s, FWD ? 1 : 3);
        chk("ld_use_cnt", {28'd0, o_stall_cnt}, FWD ? 1 : 3);

        // ALU producer
        do_reset();
        issue_prod(5'd7, 1'b0);
        set_cons(5'd7, 5'd1);
        run_until_issue(s);
        chk("alu_stalls", s, FWD ? 0 : 3);
        chk("alu_cnt", {28'd0, o_stall_cnt}, FWD ? 0 : 3);

        // x0 never stalls
        do_reset();
        issue_prod(5'd0, 1'b1);
        set_cons(5'd0, 5'd0);
        run_until_issue(s);
        chk("x0_stalls", s, 0);

        // jump beats a pending hazard
        do_reset();
        issue_prod(5'd5, 1'b1);
        set_cons(5'd5, 5'd5);
        i_ex_jump = 1;
        tick();
        i_ex_jump = 0;
        chk("jump_cnt", {28'd0, o_stall_cnt}, 0);
        chk("jump_sb_ex", {31'd0, dut.sb_ex.valid}, 0);
        idle();
        tick();

        // mem_busy with jump during a stall freezes everything
        do_reset();
        issue_prod(5'd7, 1'b1);
        set_cons(5'd7, 5'd7);
        i_ex_jump = 1; i_mem_busy = 1;
        repeat (4) tick();
        chk("busy_cnt", {28'd0, o_stall_cnt}, 0);
        chk("busy_sb_ex", {31'd0, dut.sb_ex.valid}, 1);
        i_ex_jump = 0; i_mem_busy = 0;
        run_until_issue(s);
        chk("busy_stalls", s, FWD ? 1 : 3);
        chk("busy_cnt_end", {28'd0, o_stall_cnt}, FWD ? 1 : 3);

        // reset mid-stall clears the pending hazard
        do_reset();
        issue_prod(5'd9, 1'b1);
        set_cons(5'd9, 5'd9);
        tick();
        rst = 1;
        tick();
        rst = 0;
        run_until_issue(s);
        chk("rst_mid_stalls", s, 0);

        // saturation at 15
        do_reset();
        total = 0;
        for (int p = 0; p < 20 && total < 17; p++) begin
            issue_prod(5'd3, 1'b1);
            set_cons(5'd3, 5'd3);
            tick();
            while (held && total < 17) begin
                total++;
                if (total == 14) chk("cnt_at_14", {28'd0, o_stall_cnt}, 14);
                tick();
            end
        end
        chk("sat_total", total, 17);
        chk("cnt_sat", {28'd0, o_stall_cnt}, CMAX);
        do_reset();
        chk("sat_rst_cnt", {28'd0, o_stall_cnt}, 0);
        chk("sat_rst_sb", {29'd0, dut.sb_ex.valid, dut.sb_mem.valid, dut.sb_wb.valid}, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
